// File: rtl/synchronize.sv
// synchronize: 1000BASE-X PCS receive code-group qualification and synchronization.
// Code groups are {a,b,c,d,e,i,f,g,h,j} with bit 'a' in rx_code_group[9].
module synchronize #(
  parameter int unsigned GOOD_CGS_MAX = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [9:0] rx_code_group,
  input  logic       signal_detect,
  output logic [9:0] SUDI,
  output logic       EVEN,
  output logic       sync_status
);

  localparam logic [1:0] GOOD_MAX  = GOOD_CGS_MAX[1:0];
  localparam logic [9:0] K28_5_NEG = 10'b001111_1010;
  localparam logic [9:0] K28_5_POS = 10'b110000_0101;

  typedef enum logic [3:0] {
    LOSS_OF_SYNC, COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3,
    ACQUIRE_SYNC_1, ACQUIRE_SYNC_2,
    SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4,
    SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] sudi_q, sudi_d;
  logic       even_q, even_d;
  logic [1:0] good_cgs_q, good_cgs_d;

  logic comma, data, valid, cgbad, even_comma, enter_cd;

  function automatic logic [2:0] ones6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // A data group is a legal 6b sub-block followed by a 4b sub-block legal for
  // the running disparity left by that 6b block (either starting disparity).
  function automatic logic is_data(input logic [9:0] cg);
    logic [5:0] s6;
    logic [3:0] s4;
    logic [2:0] n;
    logic       mid_neg, mid_pos, a7_neg, a7_pos, ok_neg, ok_pos;
    s6      = cg[9:4];
    s4      = cg[3:0];
    n       = ones6(s6);
    mid_neg = 1'b0;
    mid_pos = 1'b0;
    if (n == 3'd3) begin
      mid_neg = (s6 != 6'b000111);
      mid_pos = (s6 != 6'b111000);
    end else if (n == 3'd4) begin
      mid_pos = (s6 != 6'b111100) && (s6 != 6'b001111);
    end else if (n == 3'd2) begin
      mid_neg = (s6 != 6'b000011) && (s6 != 6'b110000);
    end
    a7_neg = (s6 == 6'b100011) || (s6 == 6'b010011) || (s6 == 6'b001011);
    a7_pos = (s6 == 6'b110100) || (s6 == 6'b101100) || (s6 == 6'b011100);
    case (s4)
      4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110: ok_neg = 1'b1;
      4'b1110: ok_neg = !a7_neg;
      4'b0111: ok_neg = a7_neg;
      default: ok_neg = 1'b0;
    endcase
    case (s4)
      4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110: ok_pos = 1'b1;
      4'b0001: ok_pos = !a7_pos;
      4'b1000: ok_pos = a7_pos;
      default: ok_pos = 1'b0;
    endcase
    return (mid_neg && ok_neg) || (mid_pos && ok_pos);
  endfunction

  // /T/ = K23.7, /R/ = K27.7, /S/ = K29.7, both disparities.
  function automatic logic is_trs(input logic [9:0] cg);
    return (cg == 10'b111010_1000) || (cg == 10'b000101_0111) ||
           (cg == 10'b110110_1000) || (cg == 10'b001001_0111) ||
           (cg == 10'b101110_1000) || (cg == 10'b010001_0111);
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

  always_comb begin
    comma      = (rx_code_group == K28_5_NEG) || (rx_code_group == K28_5_POS);
    data       = is_data(rx_code_group);
    valid      = data || comma || is_trs(rx_code_group);
    even_comma = comma && !even_q;
    cgbad      = !valid || (comma && even_q);
    state_d    = state_q;
    good_cgs_d = 2'd0;
    enter_cd   = 1'b0;
    sudi_d     = rx_code_group;
    if (!signal_detect) begin
      state_d = LOSS_OF_SYNC;
    end else begin
      case (state_q)
        LOSS_OF_SYNC: if (comma) begin state_d = COMMA_DETECT_1; enter_cd = 1'b1; end
        COMMA_DETECT_1: state_d = data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
        COMMA_DETECT_2: state_d = data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
        COMMA_DETECT_3: state_d = data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
        ACQUIRE_SYNC_1:
          if (cgbad) state_d = LOSS_OF_SYNC;
          else if (even_comma) begin state_d = COMMA_DETECT_2; enter_cd = 1'b1; end
        ACQUIRE_SYNC_2:
          if (cgbad) state_d = LOSS_OF_SYNC;
          else if (even_comma) begin state_d = COMMA_DETECT_3; enter_cd = 1'b1; end
        SYNC_ACQUIRED_1: if (cgbad) state_d = SYNC_ACQUIRED_2;
        SYNC_ACQUIRED_2: state_d = cgbad ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
        SYNC_ACQUIRED_3: state_d = cgbad ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
        SYNC_ACQUIRED_4: state_d = cgbad ? LOSS_OF_SYNC    : SYNC_ACQUIRED_4A;
        SYNC_ACQUIRED_2A:
          if (cgbad) state_d = SYNC_ACQUIRED_3;
          else if (good_cgs_q == GOOD_MAX) state_d = SYNC_ACQUIRED_1;
        SYNC_ACQUIRED_3A:
          if (cgbad) state_d = SYNC_ACQUIRED_4;
          else if (good_cgs_q == GOOD_MAX) state_d = SYNC_ACQUIRED_2;
        SYNC_ACQUIRED_4A:
          if (cgbad) state_d = LOSS_OF_SYNC;
          else if (good_cgs_q == GOOD_MAX) state_d = SYNC_ACQUIRED_3;
        default: state_d = LOSS_OF_SYNC;
      endcase
    end
    // The good-group count only survives while counting inside an xA state.
    if (state_d == SYNC_ACQUIRED_2A || state_d == SYNC_ACQUIRED_3A ||
        state_d == SYNC_ACQUIRED_4A) begin
      good_cgs_d = sat_inc(good_cgs_q);
    end
    even_d = enter_cd ? 1'b1 : !even_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= LOSS_OF_SYNC;
      sudi_q     <= 10'd0;
      even_q     <= 1'b0;
      good_cgs_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      sudi_q     <= sudi_d;
      even_q     <= even_d;
      good_cgs_q <= good_cgs_d;
    end
  end

  assign SUDI        = sudi_q;
  assign EVEN        = even_q;
  assign sync_status = (state_q == SYNC_ACQUIRED_1)  || (state_q == SYNC_ACQUIRED_2)  ||
                       (state_q == SYNC_ACQUIRED_3)  || (state_q == SYNC_ACQUIRED_4)  ||
                       (state_q == SYNC_ACQUIRED_2A) || (state_q == SYNC_ACQUIRED_3A) ||
                       (state_q == SYNC_ACQUIRED_4A);

endmodule

// File: tb/tb_synchronize.sv
// Directed bench for synchronize: acquisition, loss, re-sync, reset and
// code-group classification edge cases with hand-derived EVEN/sync traces.
module tb_synchronize;

  localparam logic [9:0] K    = 10'h0FA;  // K28.5 RD-
  localparam logic [9:0] KP   = 10'h305;  // K28.5 RD+
  localparam logic [9:0] D    = 10'h2AA;  // D21.5
  localparam logic [9:0] D177 = 10'h237;  // D17.7 RD- (alternate 7 encoding)
  localparam logic [9:0] D70  = 10'h38B;  // D7.0 RD-
  localparam logic [9:0] XA7  = 10'h23E;  // 100011_1110: not a data group
  localparam logic [9:0] T    = 10'h3A8;  // K23.7 RD-, valid but not data
  localparam logic [9:0] BAD0 = 10'h000;
  localparam logic [9:0] BAD1 = 10'h3FF;

  logic       CLK;
  logic       RESET;
  logic [9:0] rx_code_group;
  logic       signal_detect;
  logic [9:0] SUDI;
  logic       EVEN;
  logic       sync_status;

  int n_chk;
  int n_fail;

  synchronize #(.GOOD_CGS_MAX(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .rx_code_group(rx_code_group),
    .signal_detect(signal_detect),
    .SUDI         (SUDI),
    .EVEN         (EVEN),
    .sync_status  (sync_status)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one group, clock it in, then check the registered outputs.
  task automatic cyc(input string tag, input logic [9:0] cg, input logic sd,
                     input logic rst, input logic exp_even, input logic exp_sync);
    logic [9:0] exp_sudi;
    rx_code_group = cg;
    signal_detect = sd;
    RESET         = rst;
    @(posedge CLK);
    #1;
    exp_sudi = rst ? 10'd0 : cg;
    chk({tag, ".sudi"}, {22'd0, SUDI}, {22'd0, exp_sudi});
    chk({tag, ".even"}, {31'd0, EVEN}, {31'd0, exp_even});
    chk({tag, ".sync"}, {31'd0, sync_status}, {31'd0, exp_sync});
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    RESET         = 1'b1;
    rx_code_group = 10'd0;
    signal_detect = 1'b1;

    cyc("rst0", D, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("rst1", K, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst.gcs", {30'd0, dut.good_cgs_q}, 32'd0);

    // Acquisition: K D K D K D
    cyc("acq1", K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("acq2", D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("acq3", K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("acq4", D177, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("acq5", KP,   1'b1, 1'b0, 1'b1, 1'b0);
    cyc("acq6", D,    1'b1, 1'b0, 1'b0, 1'b1);

    // One bad group then four good groups climb back to SYNC_ACQUIRED_1
    cyc("rec1", BAD0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("rec2", D,    1'b1, 1'b0, 1'b0, 1'b1);
    cyc("rec3", D,    1'b1, 1'b0, 1'b1, 1'b1);
    cyc("rec4", D,    1'b1, 1'b0, 1'b0, 1'b1);
    chk("rec.gcs3", {30'd0, dut.good_cgs_q}, 32'd3);
    cyc("rec5", D,    1'b1, 1'b0, 1'b1, 1'b1);
    cyc("rec6", BAD0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("rec7", BAD0, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("rec8", BAD0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("rec9", BAD0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Odd comma during acquisition, then restart
    cyc("odd1", D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("odd2", D,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("odd3", K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("odd4", D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("odd5", D,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("odd6", K,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("odd7", K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("odd8", D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("odd9", K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("oddA", D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("oddB", K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("oddC", D,    1'b1, 1'b0, 1'b0, 1'b1);

    // Four consecutive invalid groups lose sync on the fourth
    cyc("los1", BAD1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("los2", BAD0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("los3", BAD1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("los4", BAD0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Re-acquire, then a one-cycle signal_detect drop
    cyc("sd1",  K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("sd2",  D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("sd3",  K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("sd4",  D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("sd5",  K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("sd6",  D,    1'b1, 1'b0, 1'b0, 1'b1);
    cyc("sd7",  D,    1'b0, 1'b0, 1'b1, 1'b0);
    cyc("sd8",  D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("sd9",  K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("sdA",  D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("sdB",  K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("sdC",  D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("sdD",  K,    1'b1, 1'b0, 1'b1, 1'b0);
    // Valid non-data /T/ after the third comma aborts acquisition
    cyc("sdE",  T,    1'b1, 1'b0, 1'b0, 1'b0);

    // 100011_1110 is not data; D7.0 is
    cyc("cls1", K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("cls2", XA7,  1'b1, 1'b0, 1'b0, 1'b0);
    cyc("cls3", K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("cls4", D70,  1'b1, 1'b0, 1'b0, 1'b0);
    cyc("cls5", K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("cls6", D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("cls7", K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("cls8", D,    1'b1, 1'b0, 1'b0, 1'b1);
    // signal_detect low together with a bad group: straight to LOSS_OF_SYNC
    cyc("cls9", BAD0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reach SYNC_ACQUIRED_2A, then reset
    cyc("rs1",  K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("rs2",  D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("rs3",  K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("rs4",  D,    1'b1, 1'b0, 1'b0, 1'b0);
    cyc("rs5",  K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("rs6",  D,    1'b1, 1'b0, 1'b0, 1'b1);
    cyc("rs7",  BAD1, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("rs8",  D,    1'b1, 1'b0, 1'b0, 1'b1);
    chk("rs8.gcs", {30'd0, dut.good_cgs_q}, 32'd1);
    cyc("rs9",  D,    1'b1, 1'b1, 1'b0, 1'b0);
    chk("rs9.gcs", {30'd0, dut.good_cgs_q}, 32'd0);
    cyc("rsA",  D,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("rsB",  K,    1'b1, 1'b0, 1'b1, 1'b0);
    cyc("rsC",  D,    1'b1, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
